i2s_tx_frame: RTL and testbench

Parametrised successor of the audio serial transmitter. Serialises multi-channel sample frames onto a bit-clock/word-select/data link in Philips I2S, left-justified or TDM (DSP-A) format. Samples arrive through a valid/ready stream into a frame FIFO; the bit clock is derived from `clk` by an integer divider. Sits between the audio datapath and the pad ring; the link side is a plain I2S master.

---
 rtl/i2s_pkg.sv | 34 +++
 rtl/sync_fifo.sv | 79 +++++++
 rtl/i2s_tx_frame.sv | 193 +++++++++++++++++++
 tb/tb_i2s_tx_frame.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types for the I2S frame transmitter.
// Link formats, FSM states and the effective-mode helper.
package i2s_pkg;

    typedef enum logic [1:0] {
        I2S_PHILIPS,
        I2S_LJ,
        I2S_TDM
    } i2s_mode_e;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } tx_state_e;

    // Two-channel formats only make sense with exactly two
    // channels; everything else falls back to a TDM frame sync.
    function automatic i2s_mode_e eff_mode(
        input logic [1:0] m,
        input int         nch
    );
        if (nch != 2) begin
            return I2S_TDM;
        end
        if (m == 2'd0) begin
            return I2S_PHILIPS;
        end
        if (m == 2'd1) begin
            return I2S_LJ;
        end
        return I2S_TDM;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock frame FIFO with registered ready.
// Ports: i_clk, i_rst (sync, high), i_push/i_data, i_pop/o_data,
// o_full, o_empty, o_level (frames held), o_ready (registered !full).
module sync_fifo
    import i2s_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_level,
    output logic                       o_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [LW-1:0]    r_cnt;
    logic             r_ready;

    logic             w_push;
    logic             w_pop;
    logic [LW-1:0]    w_cnt_nxt;

    assign o_full  = (r_cnt == LW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    assign o_data  = r_mem[r_rp];
    assign o_level = r_cnt;
    assign o_ready = r_ready;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end else if (w_pop && !w_push) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wp] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            r_cnt   <= w_cnt_nxt;
            // Ready looks one push ahead so it drops on the
            // edge that fills the last entry.
            r_ready <= (w_cnt_nxt != LW'(DEPTH));
        end
    end

endmodule

// File: rtl/i2s_tx_frame.sv
// i2s_tx_frame: multi-channel I2S / LJ / TDM master transmitter.
// Ports: clk, rst (sync, high), enable, mode, s_valid/s_ready/s_data
// stream in, fifo_level, busy, underrun, SCLK/WS/SD link out.
module i2s_tx_frame
    import i2s_pkg::*;
#(
    parameter int DWIDTH     = 16,
    parameter int SLOT_WIDTH = 32,
    parameter int NCH        = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [1:0]                      mode,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [NCH*DWIDTH-1:0]           s_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            busy,
    output logic                            underrun,
    output logic                            SCLK,
    output logic                            WS,
    output logic                            SD
);

    localparam int unsigned FRAME_U = NCH * SLOT_WIDTH;
    localparam int unsigned SLOT_U  = SLOT_WIDTH;
    localparam int unsigned DW_U    = DWIDTH;
    localparam int FW  = NCH * DWIDTH;
    localparam int PW  = (FRAME_U > 1) ? $clog2(FRAME_U) : 1;
    localparam int SBW = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
    localparam int DVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LW  = $clog2(FIFO_DEPTH + 1);

    tx_state_e      r_state;
    i2s_mode_e      r_mode;
    logic [DVW-1:0] r_div;
    logic [PW-1:0]  r_pos;
    logic [SBW-1:0] r_bit;
    logic [FW-1:0]  r_shift;
    logic           r_sclk;
    logic           r_ws;
    logic           r_sd;
    logic           r_busy;
    logic           r_underrun;

    i2s_mode_e      w_mode_in;
    logic           w_half;
    logic           w_fall;
    logic           w_last;
    logic           w_bit_last;
    logic [PW-1:0]  w_pos_nxt;
    logic [SBW-1:0] w_bit_nxt;
    logic           w_start;
    logic           w_wrap;
    logic           w_pop;
    logic           w_push;
    logic [FW-1:0]  w_dout;
    logic [FW-1:0]  w_frame;
    logic           w_full;
    logic           w_empty;
    logic           w_ready;
    logic [LW-1:0]  w_level;

    // WS level for frame position q under mode m.
    function automatic logic f_ws(
        input i2s_mode_e     m,
        input logic [PW-1:0] q
    );
        int unsigned qi;
        qi = 32'(q);
        unique case (m)
            I2S_PHILIPS: f_ws = ((qi + 1) % FRAME_U) >= SLOT_U;
            I2S_LJ:      f_ws = (qi < SLOT_U);
            default:     f_ws = (qi == FRAME_U - 1);
        endcase
    endfunction

    assign w_mode_in  = eff_mode(mode, NCH);
    assign w_half     = (r_div == DVW'(CLK_DIV - 1));
    assign w_fall     = (r_state == S_RUN) && w_half && r_sclk;
    assign w_last     = (r_pos == PW'(FRAME_U - 1));
    assign w_bit_last = (r_bit == SBW'(SLOT_WIDTH - 1));
    assign w_pos_nxt  = w_last ? '0 : r_pos + 1'b1;
    assign w_bit_nxt  = w_bit_last ? '0 : r_bit + 1'b1;

    // A frame is popped when leaving IDLE and when the last
    // position ends with the link still enabled.
    assign w_start = (r_state == S_IDLE) && enable;
    assign w_wrap  = w_fall && w_last && enable;
    assign w_pop   = w_start || w_wrap;
    assign w_push  = s_valid && w_ready && !w_full;
    assign w_frame = w_empty ? '0 : w_dout;

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_data  (s_data),
        .i_pop   (w_pop),
        .o_data  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level),
        .o_ready (w_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mode     <= I2S_PHILIPS;
            r_div      <= '0;
            r_pos      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_sclk     <= 1'b0;
            r_ws       <= 1'b0;
            r_sd       <= 1'b0;
            r_busy     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_pop && w_empty;
            unique case (r_state)
                S_IDLE: begin
                    r_mode <= w_mode_in;
                    r_div  <= '0;
                    r_pos  <= '0;
                    r_bit  <= '0;
                    r_sclk <= 1'b0;
                    r_ws   <= 1'b0;
                    r_sd   <= 1'b0;
                    r_busy <= 1'b0;
                    if (enable) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_ws    <= f_ws(w_mode_in, '0);
                        r_sd    <= w_frame[FW-1];
                        r_shift <= w_frame << 1;
                    end
                end
                S_RUN: begin
                    if (w_half) begin
                        r_div  <= '0;
                        r_sclk <= !r_sclk;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                    if (w_fall) begin
                        r_pos <= w_pos_nxt;
                        r_bit <= w_bit_nxt;
                        if (w_last && !enable) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_ws    <= 1'b0;
                            r_sd    <= 1'b0;
                        end else if (w_last) begin
                            r_ws    <= f_ws(r_mode, '0);
                            r_sd    <= w_frame[FW-1];
                            r_shift <= w_frame << 1;
                        end else begin
                            r_ws <= f_ws(r_mode, w_pos_nxt);
                            // Past the sample bits of a slot the
                            // line carries zero padding.
                            if (32'(w_bit_nxt) < DW_U) begin
                                r_sd    <= r_shift[FW-1];
                                r_shift <= r_shift << 1;
                            end else begin
                                r_sd <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign s_ready    = w_ready;
    assign fifo_level = w_level;
    assign busy       = r_busy;
    assign underrun   = r_underrun;
    assign SCLK       = r_sclk;
    assign WS         = r_ws;
    assign SD         = r_sd;

endmodule

// File: tb/tb_i2s_tx_frame.sv
// tb_i2s_tx_frame: directed bench for i2s_tx_frame.
// Unit A: 2ch x 16-bit slots; unit B: 4ch x 24-bit slots.
module tb_i2s_tx_frame;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_en = 1'b0;
    logic [1:0]  a_mode = 2'd0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [31:0] a_data = '0;
    logic [2:0]  a_lvl;
    logic        a_busy, a_urun, a_sclk, a_ws, a_sd;

    logic        b_en = 1'b0;
    logic [1:0]  b_mode = 2'd0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [63:0] b_data = '0;
    logic [2:0]  b_lvl;
    logic        b_busy, b_urun, b_sclk, b_ws, b_sd;

    int total = 0;
    int bad = 0;

    logic [95:0] sdw, wsw;
    int          ur, fr, per, gl, icyc;
    bit          tmo;
    logic [2:0]  lv0;
    logic        rd0;

    i2s_tx_frame #(
        .DWIDTH(16), .SLOT_WIDTH(16), .NCH(2),
        .FIFO_DEPTH(4), .CLK_DIV(2)
    ) u_a (
        .clk(clk), .rst(rst), .enable(a_en), .mode(a_mode),
        .s_valid(a_valid), .s_ready(a_ready), .s_data(a_data),
        .fifo_level(a_lvl), .busy(a_busy), .underrun(a_urun),
        .SCLK(a_sclk), .WS(a_ws), .SD(a_sd)
    );

    i2s_tx_frame #(
        .DWIDTH(16), .SLOT_WIDTH(24), .NCH(4),
        .FIFO_DEPTH(4), .CLK_DIV(2)
    ) u_b (
        .clk(clk), .rst(rst), .enable(b_en), .mode(b_mode),
        .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data),
        .fifo_level(b_lvl), .busy(b_busy), .underrun(b_urun),
        .SCLK(b_sclk), .WS(b_ws), .SD(b_sd)
    );

    function automatic logic [95:0] expand(input logic [63:0] f);
        return {f[63:48], 8'h00, f[47:32], 8'h00,
                f[31:16], 8'h00, f[15:0], 8'h00};
    endfunction

    task automatic push(input bit sel, input logic [63:0] d);
        int t;
        t = 0;
        if (sel) begin
            b_valid = 1'b1; b_data = d;
        end else begin
            a_valid = 1'b1; a_data = d[31:0];
        end
        while (!(sel ? b_ready : a_ready) && t < 100) begin
            @(negedge clk); t++;
        end
        total++;
        if (t >= 100) begin
            bad++; $display("FAIL push_timeout: ready=0 want 1");
        end
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
    endtask

    // Receiver: samples SD/WS on each SCLK rise, MSB first.
    task automatic capture(
        input  bit          sel,
        input  int          nbits,
        input  int          drop_at,
        output logic [95:0] sd_w,
        output logic [95:0] ws_w,
        output int          urun,
        output int          first_rise,
        output int          period,
        output int          glitch,
        output logic [2:0]  lvl_0,
        output logic        rdy_0,
        output bit          to
    );
        int n, cyc, last;
        bit first;
        logic ps, psd, pws, c_sclk, c_sd, c_ws;
        n = 0; cyc = 0; last = 0; first = 1'b1;
        sd_w = '0; ws_w = '0; urun = 0; glitch = 0;
        first_rise = -1; period = -1; to = 1'b0;
        ps = 1'b0; psd = 1'b0; pws = 1'b0;
        @(negedge clk);
        while (!(sel ? b_busy : a_busy) && !to) begin
            @(negedge clk); cyc++;
            if (cyc > 100) to = 1'b1;
        end
        cyc = 0;
        lvl_0 = sel ? b_lvl : a_lvl;
        rdy_0 = sel ? b_ready : a_ready;
        while (n < nbits && !to) begin
            c_sclk = sel ? b_sclk : a_sclk;
            c_sd   = sel ? b_sd : a_sd;
            c_ws   = sel ? b_ws : a_ws;
            if (sel ? b_urun : a_urun) urun++;
            if (!first) begin
                if ((c_sd !== psd || c_ws !== pws) && !(ps && !c_sclk))
                    glitch++;
                if (!ps && c_sclk) begin
                    sd_w = {sd_w[94:0], c_sd};
                    ws_w = {ws_w[94:0], c_ws};
                    if (n == 0) first_rise = cyc;
                    else if (n == 1) period = cyc - last;
                    last = cyc;
                    n++;
                    if (n == drop_at) begin
                        if (sel) b_en = 1'b0;
                        else a_en = 1'b0;
                    end
                end
            end
            ps = c_sclk; psd = c_sd; pws = c_ws; first = 1'b0;
            if (n < nbits) begin
                @(negedge clk); cyc++;
                if (cyc > nbits * 8 + 20) to = 1'b1;
            end
        end
    endtask

    task automatic wait_idle(input bit sel, output int cyc, output bit to);
        cyc = 0; to = 1'b0;
        while ((sel ? b_busy : a_busy) && !to) begin
            @(negedge clk); cyc++;
            if (cyc > 50) to = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({a_sclk, a_ws, a_sd, a_busy, a_urun, a_ready} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outs: got %b want 000000",
                {a_sclk, a_ws, a_sd, a_busy, a_urun, a_ready});
        end
        total++;
        if (a_lvl !== 3'd0) begin
            bad++; $display("FAIL reset_level: got %0d want 0", a_lvl);
        end
        total++;
        if (b_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready_b: got %b want 0", b_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset: got %b%b want 11", a_ready, b_ready);
        end
        total++;
        if (a_lvl !== 3'd0 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: lvl=%0d busy=%b want 0 0", a_lvl, a_busy);
        end
    endtask

    task automatic test_i2s();
        push(1'b0, 64'hA5A5_3C3C);
        a_mode = 2'd0; a_en = 1'b1;
        capture(1'b0, 32, 1, sdw, wsw, ur, fr, per, gl, lv0, rd0, tmo);
        total++;
        if (tmo) begin bad++; $display("FAIL i2s_timeout: no frame, want 32 bits"); end
        total++;
        if (sdw[31:0] !== 32'hA5A5_3C3C) begin
            bad++; $display("FAIL i2s_data: got %h want a5a53c3c", sdw[31:0]);
        end
        total++;
        if (wsw[31:0] !== 32'h0001_FFFE) begin
            bad++; $display("FAIL i2s_ws: got %h want 0001fffe", wsw[31:0]);
        end
        total++;
        if (ur !== 0) begin bad++; $display("FAIL i2s_underrun: got %0d want 0", ur); end
        total++;
        if (fr !== 2 || per !== 4) begin
            bad++; $display("FAIL i2s_sclk: first=%0d period=%0d want 2 4", fr, per);
        end
        total++;
        if (gl !== 0) begin bad++; $display("FAIL i2s_stable: got %0d want 0", gl); end
        wait_idle(1'b0, icyc, tmo);
        total++;
        if (tmo || icyc !== 2) begin
            bad++; $display("FAIL i2s_stop: cycles=%0d want 2", icyc);
        end
        total++;
        if ({a_sclk, a_ws, a_sd} !== 3'b000) begin
            bad++; $display("FAIL i2s_idle_lines: got %b want 000", {a_sclk, a_ws, a_sd});
        end
    endtask

    task automatic test_lj();
        push(1'b0, 64'h1234_8001);
        a_mode = 2'd1; a_en = 1'b1;
        capture(1'b0, 32, 1, sdw, wsw, ur, fr, per, gl, lv0, rd0, tmo);
        total++;
        if (tmo || sdw[31:0] !== 32'h1234_8001) begin
            bad++; $display("FAIL lj_data: got %h want 12348001", sdw[31:0]);
        end
        total++;
        if (wsw[31:0] !== 32'hFFFF_0000) begin
            bad++; $display("FAIL lj_ws: got %h want ffff0000", wsw[31:0]);
        end
        wait_idle(1'b0, icyc, tmo);
    endtask

    task automatic test_underrun();
        a_mode = 2'd0;
        a_en = 1'b1; a_valid = 1'b1; a_data = 32'h5A5A_C3C3;
        @(posedge clk); #1;
        a_valid = 1'b0;
        capture(1'b0, 32, 0, sdw, wsw, ur, fr, per, gl, lv0, rd0, tmo);
        total++;
        if (tmo || sdw[31:0] !== 32'h0) begin
            bad++; $display("FAIL urun_zero_frame: got %h want 00000000", sdw[31:0]);
        end
        total++;
        if (ur !== 1) begin bad++; $display("FAIL urun_pulse: got %0d want 1", ur); end
        total++;
        if (a_lvl !== 3'd1) begin
            bad++; $display("FAIL urun_level: got %0d want 1", a_lvl);
        end
        capture(1'b0, 32, 1, sdw, wsw, ur, fr, per, gl, lv0, rd0, tmo);
        total++;
        if (tmo || sdw[31:0] !== 32'h5A5A_C3C3) begin
            bad++; $display("FAIL urun_next_frame: got %h want 5a5ac3c3", sdw[31:0]);
        end
        total++;
        if (ur !== 0 || wsw[31:0] !== 32'h0001_FFFE) begin
            bad++; $display("FAIL urun_next_ws: urun=%0d ws=%h want 0 0001fffe", ur, wsw[31:0]);
        end
        wait_idle(1'b0, icyc, tmo);
        total++;
        if (tmo || a_lvl !== 3'd0) begin
            bad++; $display("FAIL urun_drain: level=%0d want 0", a_lvl);
        end
    endtask

    task automatic test_fill_drop();
        logic [31:0] fr_a [4];
        fr_a[0] = 32'h0F0F_F0F0; fr_a[1] = 32'h8000_0001;
        fr_a[2] = 32'hCAFE_BABE; fr_a[3] = 32'h1357_9BDF;
        for (int i = 0; i < 4; i++) push(1'b0, {32'h0, fr_a[i]});
        total++;
        if (a_lvl !== 3'd4 || a_ready !== 1'b0) begin
            bad++; $display("FAIL fill: level=%0d ready=%b want 4 0", a_lvl, a_ready);
        end
        a_valid = 1'b1; a_data = 32'hDEAD_DEAD;
        repeat (3) @(negedge clk);
        a_valid = 1'b0;
        total++;
        if (a_lvl !== 3'd4) begin
            bad++; $display("FAIL full_reject: level=%0d want 4", a_lvl);
        end
        a_mode = 2'd0; a_en = 1'b1;
        capture(1'b0, 32, 6, sdw, wsw, ur, fr, per, gl, lv0, rd0, tmo);
        total++;
        if (lv0 !== 3'd3 || rd0 !== 1'b1) begin
            bad++; $display("FAIL pop_start: level=%0d ready=%b want 3 1", lv0, rd0);
        end
        total++;
        if (tmo || sdw[31:0] !== fr_a[0] || ur !== 0) begin
            bad++; $display("FAIL drop_frame: got %h urun=%0d want %h 0", sdw[31:0], ur, fr_a[0]);
        end
        wait_idle(1'b0, icyc, tmo);
        total++;
        if (tmo || icyc !== 2 || a_lvl !== 3'd3) begin
            bad++; $display("FAIL drop_stop: cycles=%0d level=%0d want 2 3", icyc, a_lvl);
        end
        a_en = 1'b1;
        capture(1'b0, 11, 0, sdw, wsw, ur, fr, per, gl, lv0, rd0, tmo);
        total++;
        if (tmo || sdw[10:0] !== fr_a[1][31:21]) begin
            bad++; $display("FAIL pre_rst_bits: got %h want %h", sdw[10:0], fr_a[1][31:21]);
        end
        rst = 1'b1; a_en = 1'b0;
        @(negedge clk);
        total++;
        if ({a_busy, a_sclk, a_ws, a_sd, a_ready, a_urun} !== 6'b0 || a_lvl !== 3'd0) begin
            bad++;
            $display("FAIL mid_rst: outs=%b level=%0d want 000000 0",
                {a_busy, a_sclk, a_ws, a_sd, a_ready, a_urun}, a_lvl);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (a_ready !== 1'b1 || a_busy !== 1'b0 || a_lvl !== 3'd0) begin
            bad++;
            $display("FAIL post_rst: ready=%b busy=%b level=%0d want 1 0 0", a_ready, a_busy, a_lvl);
        end
    endtask

    task automatic test_back_to_back_b();
        logic [63:0] fb [6];
        int nf;
        fb[0] = 64'h1111_2222_3333_4444; fb[1] = 64'hFFFF_0000_8001_7FFE;
        fb[2] = 64'hDEAD_BEEF_CAFE_F00D; fb[3] = 64'h0123_4567_89AB_CDEF;
        fb[4] = 64'hA5A5_5A5A_0F0F_F0F0; fb[5] = 64'h8000_0001_0000_FFFF;
        for (int g = 0; g < 2; g++) begin
            b_mode = (g == 0) ? 2'd1 : 2'd3;
            nf = (g == 0) ? 4 : 2;
            for (int i = 0; i < nf; i++) push(1'b1, fb[g * 4 + i]);
            b_en = 1'b1;
            for (int i = 0; i < nf; i++) begin
                capture(1'b1, 96, (i == nf - 1) ? 1 : 0,
                    sdw, wsw, ur, fr, per, gl, lv0, rd0, tmo);
                total++;
                if (tmo || sdw !== expand(fb[g * 4 + i])) begin
                    bad++;
                    $display("FAIL b_data%0d_%0d: got %h want %h",
                        g, i, sdw, expand(fb[g * 4 + i]));
                end
                total++;
                if (wsw !== 96'h1 || ur !== 0 || gl !== 0) begin
                    bad++;
                    $display("FAIL b_ws%0d_%0d: ws=%h urun=%0d glitch=%0d want 1 0 0",
                        g, i, wsw, ur, gl);
                end
            end
            wait_idle(1'b1, icyc, tmo);
            total++;
            if (tmo || b_lvl !== 3'd0) begin
                bad++; $display("FAIL b_stop%0d: level=%0d want 0", g, b_lvl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_i2s();
        test_lj();
        test_underrun();
        test_fill_drop();
        test_back_to_back_b();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
